// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, supporting gapless back-to-back words.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_armed;
  logic             w_last;
  logic             w_handshake;

  // r_armed keeps load_ready low while reset is held and until the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  assign w_last      = (r_state == SHIFT) && (r_cnt == LAST);
  assign load_ready  = r_armed && ((r_state == IDLE) || w_last);
  assign w_handshake = load_valid && load_ready;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_state_nxt = SHIFT;
          w_shreg_nxt = load_data;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (w_last) begin
          // Reloading here is what makes consecutive words gapless.
          if (w_handshake) begin
            w_shreg_nxt = load_data;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
            w_shreg_nxt = w_shifted;
          end
        end else begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; nothing reaches them from load_valid.
  assign sout_valid = (r_state == SHIFT);
  assign done       = w_last;
  assign sout       = (r_state == SHIFT) ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]) : 1'b0;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance,
// table-driven per-cycle vectors plus hand-written reset sequences.
module tb_piso_serializer;

  logic       clk;
  logic       reset;
  logic       lv0, lv1;
  logic [7:0] ld0, ld1;
  logic       rdy0, so0, sv0, dn0;
  logic       rdy1, so1, sv1, dn1;

  int n_chk  = 0;
  int n_pass = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .load_valid(lv0), .load_data(ld0),
    .load_ready(rdy0), .sout(so0), .sout_valid(sv0), .done(dn0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_data(ld1),
    .load_ready(rdy1), .sout(so1), .sout_valid(sv1), .done(dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    logic       lv;
    logic [7:0] d;
    logic       so;
    logic       sv;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
  endtask

  task automatic add(input bit sel, input logic lv, input logic [7:0] d,
                     input logic so, input logic sv, input logic dn, input logic rdy);
    vec_t v;
    v.sel = sel; v.lv = lv; v.d = d; v.so = so; v.sv = sv; v.dn = dn; v.rdy = rdy;
    vq.push_back(v);
  endtask

  // Eight SHIFT cycles; seq[7] is the first transmitted bit, lvm[7] the load_valid of the first cycle.
  task automatic add_word(input bit sel, input logic [7:0] lvm, input logic [7:0] d,
                          input logic [7:0] seq);
    for (int k = 1; k <= 8; k++) begin
      add(sel, lvm[8-k], d, seq[8-k], 1'b1, (k == 8), (k == 8));
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    lv0 = 1'b0; lv1 = 1'b0;
    if (v.sel) begin lv1 = v.lv; ld1 = v.d; end
    else       begin lv0 = v.lv; ld0 = v.d; end
    #1;
    if (v.sel) begin
      chk("lsb_sout", idx, so1, v.so);
      chk("lsb_sout_valid", idx, sv1, v.sv);
      chk("lsb_done", idx, dn1, v.dn);
      chk("lsb_load_ready", idx, rdy1, v.rdy);
    end else begin
      chk("msb_sout", idx, so0, v.so);
      chk("msb_sout_valid", idx, sv0, v.sv);
      chk("msb_done", idx, dn0, v.dn);
      chk("msb_load_ready", idx, rdy0, v.rdy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq81;
    reset = 1'b1;
    lv0 = 1'b0; lv1 = 1'b0; ld0 = 8'h00; ld1 = 8'h00;

    // Reset held: all outputs zero, load_ready low.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sout", 0, so0, 1'b0);
    chk("rst_sout_valid", 0, sv0, 1'b0);
    chk("rst_done", 0, dn0, 1'b0);
    chk("rst_load_ready", 0, rdy0, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_ready_before_edge", 0, rdy0, 1'b0);
    @(posedge clk);
    #1;
    chk("rel_ready_after_edge", 0, rdy0, 1'b1);
    chk("rel_ready_after_edge_lsb", 0, rdy1, 1'b1);

    // Asynchronous assertion between edges.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_load_ready", 0, rdy0, 1'b0);
    chk("async_sout_valid", 0, sv0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);

    // Single word A5, MSB first.
    add(0, 1, 8'hA5, 0, 0, 0, 1);
    add_word(0, 8'h00, 8'h00, 8'b10100101);
    add(0, 0, 8'h00, 0, 0, 0, 1);
    // Back-to-back A5 then 3C with load_valid held.
    add(0, 1, 8'hA5, 0, 0, 0, 1);
    add_word(0, 8'hFF, 8'h3C, 8'b10100101);
    add_word(0, 8'h00, 8'h00, 8'b00111100);
    add(0, 0, 8'h00, 0, 0, 0, 1);
    // FF offered while 00 is busy; accepted only at the last bit.
    add(0, 1, 8'h00, 0, 0, 0, 1);
    add_word(0, 8'b01111111, 8'hFF, 8'b00000000);
    add_word(0, 8'h00, 8'h00, 8'b11111111);
    add(0, 0, 8'h00, 0, 0, 0, 1);
    // LSB first: 01 and C1.
    add(1, 1, 8'h01, 0, 0, 0, 1);
    add_word(1, 8'h00, 8'h00, 8'b10000000);
    add(1, 0, 8'h00, 0, 0, 0, 1);
    add(1, 1, 8'hC1, 0, 0, 0, 1);
    add_word(1, 8'h00, 8'h00, 8'b10000011);
    add(1, 0, 8'h00, 0, 0, 0, 1);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Reset mid-word: load F0, abort during bit 3.
    @(negedge clk);
    lv0 = 1'b1; ld0 = 8'hF0; lv1 = 1'b0;
    #1;
    chk("mid_idle_ready", 0, rdy0, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      lv0 = 1'b0;
      #1;
      chk("mid_sout", k, so0, 1'b1);
    end
    @(negedge clk);
    #1;
    chk("mid_bit3_sout", 3, so0, 1'b1);
    chk("mid_bit3_valid", 3, sv0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_sout", 0, so0, 1'b0);
    chk("mid_rst_sout_valid", 0, sv0, 1'b0);
    chk("mid_rst_done", 0, dn0, 1'b0);
    chk("mid_rst_load_ready", 0, rdy0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("mid_rst_no_done", k, dn0, 1'b0);
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_done", k, dn0, 1'b0);
      chk("post_rst_idle", k, sv0, 1'b0);
    end

    // After recovery: 81 with normal latency.
    seq81 = 8'b10000001;
    @(negedge clk);
    lv0 = 1'b1; ld0 = 8'h81;
    #1;
    chk("rec_ready", 0, rdy0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      lv0 = 1'b0; ld0 = 8'h55;
      #1;
      chk("rec_sout", k, so0, seq81[8-k]);
      chk("rec_sout_valid", k, sv0, 1'b1);
      chk("rec_done", k, dn0, (k == 8));
    end
    @(negedge clk);
    #1;
    chk("rec_idle_sout_valid", 9, sv0, 1'b0);
    chk("rec_idle_sout", 9, so0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter: the sending end of the single-bit serial link that our serial-in serial-out shift stage receives. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock on sout, qualified by sout_valid. It supports back-to-back words with no idle gap, so a downstream shift register sees a continuous bit stream.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
MSB_FIRST, 1, selects bit order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
load_valid  input  1  source has a word on load_data.
load_data  input  WIDTH  parallel word to serialize.
load_ready  output  1  serializer can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a valid data bit this cycle.
done  output  1  one-cycle pulse, high while the last bit of a word is on sout.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, named reset.
- While reset is asserted, outputs are forced immediately, without waiting for a clock edge: sout=0, sout_valid=0, done=0, load_ready=0, FSM=IDLE, bit counter=0, shift register=0.
- load_ready goes high in the first clock edge after reset deasserts.
- The FSM has two states, IDLE and SHIFT.
- IDLE:
  - load_ready=1, sout=0, sout_valid=0, done=0.
  - A handshake at a rising edge (load_valid & load_ready) loads load_data into the shift register, clears the counter, and moves the FSM to SHIFT.
- SHIFT:
  - sout_valid=1.
  - sout is shreg[WIDTH-1] when MSB_FIRST=1, otherwise shreg[0].
  - Each edge shifts the register by one position toward the output end, zero-filled, and increments the counter.
- Last bit: the cycle where counter == WIDTH-1.
  - done=1 and load_ready=1 in that cycle.
  - If a handshake occurs at the end of that cycle, the new word is loaded and the FSM stays in SHIFT. The first bit of the new word appears on the very next cycle, so there is no gap.
  - Otherwise the FSM returns to IDLE and sout drops to 0.
- In SHIFT cycles other than the last bit, load_ready=0 and load_valid is ignored. The source must hold its word until load_ready is high.
- Latency: the handshake happens at edge N. Bit k of the transmitted order is driven during the cycle after edge N+k, for k = 0 .. WIDTH-1. done is high on the cycle after edge N+WIDTH-1.
- Counter width is $clog2(WIDTH). It never wraps past WIDTH-1; it is reset to 0 on every load.
- load_data is sampled only at handshake edges. Changes to it at any other time have no effect.
- Reset asserted mid-word: the word is discarded and no done pulse is produced. After reset deasserts the block restarts in IDLE.
- Outputs are registered, or decoded purely from registered state: no combinational path from load_valid to sout, sout_valid or done.
- load_ready may depend combinationally on state only, never on load_valid.

Test Plan:
1. Reset behaviour: assert reset mid-cycle with no clock edge -> sout=0, sout_valid=0, done=0, load_ready=0 immediately. Deassert reset -> load_ready=1 after the next edge.
2. Single word, MSB_FIRST=1, 8'hA5 -> sout over 8 consecutive cycles is 1,0,1,0,0,1,0,1. sout_valid is high for exactly those 8 cycles. done is high only on the 8th. Then IDLE with sout=0.
3. Back-to-back words: 8'hA5 then 8'h3C, with load_valid held high -> 16 continuous sout_valid cycles with sout = 10100101 00111100. done pulses on cycles 8 and 16. load_ready is high only in IDLE and on cycles 8 and 16.
4. Load while busy: load_valid=1 with 8'hFF during bits 2-6 of word 8'h00 -> load_ready stays 0 and sout stays all 0. 8'hFF is accepted at the end of bit 8 and transmitted next as 8 ones.
5. LSB_FIRST (MSB_FIRST=0), word 8'h01 -> sout sequence is 1,0,0,0,0,0,0,0 and done is high on the 8th cycle.
6. Reset mid-word: load 8'hF0, then assert reset during bit 3 -> outputs go to 0 asynchronously and no done pulse occurs. After release, load 8'h81 -> sout is 1,0,0,0,0,0,0,1 with correct latency.
